// File: rtl/axis_gpio_out.sv
// axis_gpio_out
//   AXI-Stream driven GPIO output register with a minimum hold time.
//   Each accepted beat computes a new pin value from the current pins and
//   the beat operand (WRITE / SET / CLEAR / TOGGLE). When the pins actually
//   change, the block stays in HOLD for HOLD_LENGTH cycles before it accepts
//   another beat. A beat that leaves the pins unchanged starts no hold.
//
// Handshake: a beat is consumed on a rising edge where s_axis_tvalid and
//   s_axis_tready are both high. s_axis_tready never looks at s_axis_tvalid.
//   While s_axis_tready is low, tdata/tuser are ignored, and a beat held
//   valid is taken on the first edge where s_axis_tready is high.
//
// Ports:
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   s_axis_tdata   [NUM_PINS] operand
//   s_axis_tuser   [2] opcode: 00 WRITE, 01 SET, 10 CLEAR, 11 TOGGLE
//   s_axis_tvalid  beat valid
//   s_axis_tready  block accepts a beat this cycle
//   gpio_out       [NUM_PINS] registered pin drive
//   busy           high while in HOLD (this is the FSM state, exposed)
//   update         one-cycle pulse on the cycle gpio_out shows a new value
module axis_gpio_out #(
  parameter int                   NUM_PINS    = 16,
  parameter int                   HOLD_LENGTH = 10,
  parameter logic [NUM_PINS-1:0]  RESET_VALUE = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_PINS-1:0] s_axis_tdata,
  input  logic [1:0]          s_axis_tuser,
  input  logic                s_axis_tvalid,
  output logic                s_axis_tready,
  output logic [NUM_PINS-1:0] gpio_out,
  output logic                busy,
  output logic                update
);

  // Wide enough for HOLD_LENGTH-1; at least one bit so HOLD_LENGTH=1 works.
  localparam int CNT_W = (HOLD_LENGTH > 1) ? $clog2(HOLD_LENGTH) : 1;
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_LENGTH - 1);

  localparam logic [1:0] OP_WRITE  = 2'b00;
  localparam logic [1:0] OP_SET    = 2'b01;
  localparam logic [1:0] OP_CLEAR  = 2'b10;
  localparam logic [1:0] OP_TOGGLE = 2'b11;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  logic [0:0]          state;
  logic [CNT_W-1:0]    cnt;
  logic [NUM_PINS-1:0] next_val;
  logic                accept;
  logic                changed;

  always_comb begin
    next_val = s_axis_tdata;
    case (s_axis_tuser)
      OP_WRITE:  next_val = s_axis_tdata;
      OP_SET:    next_val = gpio_out | s_axis_tdata;
      OP_CLEAR:  next_val = gpio_out & ~s_axis_tdata;
      OP_TOGGLE: next_val = gpio_out ^ s_axis_tdata;
      default:   next_val = s_axis_tdata;
    endcase
  end

  // Ready in IDLE, or on the last cycle of a hold so back-to-back changing
  // beats land exactly HOLD_LENGTH edges apart. Gated by rst_n so nothing is
  // offered while reset is asserted.
  assign s_axis_tready = rst_n && ((state == IDLE) || (cnt == '0));
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign changed       = (next_val != gpio_out);
  assign busy          = (state == HOLD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      gpio_out <= RESET_VALUE;
      update   <= 1'b0;
    end else begin
      update <= 1'b0;
      if (accept) begin
        if (changed) begin
          gpio_out <= next_val;
          state    <= HOLD;
          cnt      <= HOLD_LOAD;
          update   <= 1'b1;
        end else begin
          state <= IDLE;
          cnt   <= '0;
        end
      end else if (state == HOLD) begin
        if (cnt == '0) begin
          state <= IDLE;
        end else begin
          cnt <= cnt - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_axis_gpio_out.sv
module tb_axis_gpio_out;

  localparam logic [1:0] OP_WRITE  = 2'b00;
  localparam logic [1:0] OP_SET    = 2'b01;
  localparam logic [1:0] OP_CLEAR  = 2'b10;
  localparam logic [1:0] OP_TOGGLE = 2'b11;

  // ---------------- clock / reset ----------------
  logic        clk;
  logic        rst_n;
  logic [15:0] s_axis_tdata;
  logic [1:0]  s_axis_tuser;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [15:0] gpio_out;
  logic        busy;
  logic        update;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  axis_gpio_out #(
    .NUM_PINS   (16),
    .HOLD_LENGTH(4),
    .RESET_VALUE(16'h0000)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tuser (s_axis_tuser),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .gpio_out     (gpio_out),
    .busy         (busy),
    .update       (update)
  );

  // ---------------- scoreboard ----------------
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_q[$];
  logic        exp_upd_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a negedge. Drives the beat, waits (bounded) for tready,
  // pushes the expectation, lets the edge consume it, then checks outputs
  // at the following negedge.
  task automatic send(input logic [1:0] op, input logic [15:0] d,
                      input logic [15:0] exp_val, input logic exp_upd,
                      input int exp_wait);
    int waited;
    logic [15:0] e_val;
    logic        e_upd;
    s_axis_tvalid = 1'b1;
    s_axis_tuser  = op;
    s_axis_tdata  = d;
    waited = 0;
    while (!s_axis_tready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!s_axis_tready) begin
      check("tready_timeout", 32'(waited), 32'(exp_wait));
      s_axis_tvalid = 1'b0;
      return;
    end
    check("wait_cycles", 32'(waited), 32'(exp_wait));
    exp_q.push_back(exp_val);
    exp_upd_q.push_back(exp_upd);
    @(posedge clk);
    #1;
    s_axis_tvalid = 1'b0;
    @(negedge clk);
    e_val = exp_q.pop_front();
    e_upd = exp_upd_q.pop_front();
    check("gpio_out", 32'(gpio_out), 32'(e_val));
    check("update", 32'(update), 32'(e_upd));
    // With HOLD_LENGTH=4 a change leaves the block busy and not ready.
    check("busy", 32'(busy), 32'(e_upd));
    check("tready", 32'(s_axis_tready), 32'(!e_upd));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [1:0]  op;
    logic [15:0] data;
    logic [15:0] exp_val;
    logic        exp_upd;
    int          exp_wait;
  } vec_t;

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{OP_WRITE,  16'hA5A5, 16'hA5A5, 1'b1, 0};
    vecs[1]  = '{OP_SET,    16'h000F, 16'hA5AF, 1'b1, 3};
    vecs[2]  = '{OP_CLEAR,  16'h00FF, 16'hA500, 1'b1, 3};
    vecs[3]  = '{OP_TOGGLE, 16'hFFFF, 16'h5AFF, 1'b1, 3};
    vecs[4]  = '{OP_WRITE,  16'h00F0, 16'h00F0, 1'b1, 3};
    vecs[5]  = '{OP_SET,    16'h0010, 16'h00F0, 1'b0, 3};
    vecs[6]  = '{OP_SET,    16'h0010, 16'h00F0, 1'b0, 0};
    vecs[7]  = '{OP_CLEAR,  16'h0000, 16'h00F0, 1'b0, 0};
    vecs[8]  = '{OP_TOGGLE, 16'h0000, 16'h00F0, 1'b0, 0};
    vecs[9]  = '{OP_WRITE,  16'h00F0, 16'h00F0, 1'b0, 0};
    vecs[10] = '{OP_SET,    16'hFF00, 16'hFFF0, 1'b1, 0};
    vecs[11] = '{OP_CLEAR,  16'hFFFF, 16'h0000, 1'b1, 3};
  end

  // ---------------- main sequence ----------------
  initial begin
    rst_n         = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tuser  = OP_WRITE;
    s_axis_tdata  = 16'h0000;
    repeat (3) @(negedge clk);
    check("rst_gpio", 32'(gpio_out), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_update", 32'(update), 32'h0);
    check("rst_tready", 32'(s_axis_tready), 32'h0);
    rst_n = 1'b1;
    #1;
    check("post_rst_tready", 32'(s_axis_tready), 32'h1);
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      send(vecs[i].op, vecs[i].data, vecs[i].exp_val, vecs[i].exp_upd, vecs[i].exp_wait);
    end

    // Wait out the last hold, then set a base value.
    repeat (4) @(negedge clk);
    send(OP_WRITE, 16'h00AA, 16'h00AA, 1'b1, 0);

    // Held beat during HOLD: tdata/tuser wiggle but must be ignored.
    s_axis_tvalid = 1'b1;
    s_axis_tuser  = 2'($urandom_range(0, 3));
    s_axis_tdata  = 16'($urandom_range(1, 16'hFFFF));
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("hold_gpio", 32'(gpio_out), 32'h00AA);
      check("hold_tready", 32'(s_axis_tready), 32'h0);
      check("hold_update", 32'(update), 32'h0);
      if (k == 0) begin
        s_axis_tuser = 2'($urandom_range(0, 3));
        s_axis_tdata = 16'($urandom_range(1, 16'hFFFF));
      end else begin
        s_axis_tuser = OP_WRITE;
        s_axis_tdata = 16'h1234;
      end
    end
    @(negedge clk);
    check("hold_end_gpio", 32'(gpio_out), 32'h00AA);
    send(OP_WRITE, 16'h1234, 16'h1234, 1'b1, 0);

    // Reset mid-hold at counter=2.
    @(negedge clk);
    s_axis_tvalid = 1'b1;
    s_axis_tuser  = OP_WRITE;
    s_axis_tdata  = 16'h00FF;
    rst_n = 1'b0;
    #1;
    check("abort_gpio", 32'(gpio_out), 32'h0);
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_tready", 32'(s_axis_tready), 32'h0);
    check("abort_update", 32'(update), 32'h0);
    @(negedge clk);
    check("no_accept_in_rst", 32'(gpio_out), 32'h0);
    s_axis_tvalid = 1'b0;
    rst_n = 1'b1;
    #1;
    check("release_tready", 32'(s_axis_tready), 32'h1);
    @(negedge clk);
    send(OP_WRITE, 16'h0001, 16'h0001, 1'b1, 0);

    check("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Safety net so the bench always ends on its own.
  initial begin
    #100000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
